// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the single-clock FIFO.
// Holds word width, depth, pointer width and half threshold.
package sync_fifo_pkg;

   localparam int FIFO_WIDTH = 8;
   localparam int FIFO_DEPTH = 16;
   localparam int FIFO_BITS  = 4;
   localparam int FIFO_HALF  = FIFO_DEPTH / 2;

   // Next pointer value; wraps naturally at 2**bits.
   function automatic logic [FIFO_BITS-1:0] ptr_next(
      input logic [FIFO_BITS-1:0] ptr
   );
      ptr_next = ptr + {{(FIFO_BITS-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port register array: synchronous write, addressed read.
// Ports: clock, wr_en/wr_addr/wr_data, rd_addr -> rd_data.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH,
   parameter int BITS  = FIFO_BITS
) (
   input  logic             clock,
   input  logic             wr_en,
   input  logic [BITS-1:0]  wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [BITS-1:0]  rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [2**BITS];

   // Storage is never reset; occupancy tracking makes stale words invisible.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with active-low strobes and registered read data.
// Ports: clock, reset, data_in, read_n, write_n -> data_out, full, empty, half, counter.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = sync_fifo_pkg::FIFO_WIDTH,
   parameter int FIFO_DEPTH = sync_fifo_pkg::FIFO_DEPTH,
   parameter int FIFO_BITS  = sync_fifo_pkg::FIFO_BITS,
   parameter int FIFO_HALF  = sync_fifo_pkg::FIFO_HALF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  read_n,
   input  logic                  write_n,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  half,
   output logic [FIFO_BITS:0]    counter
);

   localparam logic [FIFO_BITS:0] CNT_FULL = FIFO_DEPTH[FIFO_BITS:0];
   localparam logic [FIFO_BITS:0] CNT_HALF = FIFO_HALF[FIFO_BITS:0];
   localparam logic [FIFO_BITS:0] CNT_ONE  = {{FIFO_BITS{1'b0}}, 1'b1};
   localparam logic [FIFO_BITS-1:0] PTR_ONE = {{(FIFO_BITS-1){1'b0}}, 1'b1};

   logic [FIFO_BITS-1:0]  rd_ptr;
   logic [FIFO_BITS-1:0]  wr_ptr;
   logic [FIFO_WIDTH-1:0] mem_data;
   logic                  wr_ok;
   logic                  rd_ok;

   // Status flags decode the registered count directly.
   assign empty = (counter == '0);
   assign full  = (counter == CNT_FULL);
   assign half  = (counter >= CNT_HALF);

   // A read at empty never sees the same-cycle write (no read-through),
   // and a write at full is dropped even when a read frees a slot.
   assign wr_ok = !write_n && !full && !reset;
   assign rd_ok = !read_n && !empty && !reset;

   sync_fifo_mem #(
      .WIDTH (FIFO_WIDTH),
      .BITS  (FIFO_BITS)
   ) u_mem (
      .clock   (clock),
      .wr_en   (wr_ok),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_addr (rd_ptr),
      .rd_data (mem_data)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         counter  <= '0;
         data_out <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_ok) begin
            rd_ptr   <= rd_ptr + PTR_ONE;
            data_out <= mem_data;
         end
         unique case ({wr_ok, rd_ok})
            2'b10:   counter <= counter + CNT_ONE;
            2'b01:   counter <= counter - CNT_ONE;
            default: counter <= counter;
         endcase
      end
   end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo.
// Drives strobes 1 ns after each rising edge and checks there.
module tb_sync_fifo;
   import sync_fifo_pkg::*;

   logic                  clock;
   logic                  reset;
   logic [FIFO_WIDTH-1:0] data_in;
   logic                  read_n;
   logic                  write_n;
   logic [FIFO_WIDTH-1:0] data_out;
   logic                  full;
   logic                  empty;
   logic                  half;
   logic [FIFO_BITS:0]    counter;

   int tests;
   int failed;

   sync_fifo dut (
      .clock    (clock),
      .reset    (reset),
      .data_in  (data_in),
      .read_n   (read_n),
      .write_n  (write_n),
      .data_out (data_out),
      .full     (full),
      .empty    (empty),
      .half     (half),
      .counter  (counter)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_status(input string tag, input int cnt,
                               input int e, input int h, input int f);
      check({tag, " counter"}, int'(counter), cnt);
      check({tag, " empty"}, int'(empty), e);
      check({tag, " half"}, int'(half), h);
      check({tag, " full"}, int'(full), f);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] exp_word;
      int written;
      int cyc;
      bit wr_ok;
      bit rd_ok;

      tests   = 0;
      failed  = 0;
      reset   = 1'b1;
      read_n  = 1'b1;
      write_n = 1'b1;
      data_in = '0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check_status("reset", 0, 1, 0, 0);
      check("reset data_out", int'(data_out), 0);

      // Fill with 1..16.
      for (int i = 1; i <= 16; i++) begin
         data_in = 8'(i);
         write_n = 1'b0;
         tick();
         check_status($sformatf("fill%0d", i), i, 0,
                      (i >= 8) ? 1 : 0, (i == 16) ? 1 : 0);
      end

      // Write while full is dropped.
      data_in = 8'hAA;
      tick();
      check_status("wr_full", 16, 0, 1, 1);
      write_n = 1'b1;

      // Drain: expect 1..16 in order.
      read_n = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         check($sformatf("drain%0d data", i), int'(data_out), i);
         check($sformatf("drain%0d counter", i), int'(counter), 16 - i);
      end
      check_status("drained", 0, 1, 0, 0);

      // Reads at empty are ignored; data_out holds 16.
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rd_empty data", int'(data_out), 16);
         check("rd_empty counter", int'(counter), 0);
      end

      // Read+write at empty: only the write lands.
      data_in = 8'h33;
      write_n = 1'b0;
      tick();
      check("rw_empty counter", int'(counter), 1);
      check("rw_empty data", int'(data_out), 16);
      write_n = 1'b1;
      tick();
      check("rw_empty readback", int'(data_out), 8'h33);
      check("rw_empty after", int'(counter), 0);
      read_n = 1'b1;

      // Streaming: write every cycle, read every other cycle.
      written = 0;
      cyc     = 0;
      while ((written < 40 || q.size() > 0) && cyc < 400) begin
         write_n = (written < 40) ? 1'b0 : 1'b1;
         read_n  = (written < 40) ? ((cyc % 2 == 1) ? 1'b0 : 1'b1) : 1'b0;
         data_in = 8'h80 + 8'(written);
         wr_ok = !write_n && q.size() < 16;
         rd_ok = !read_n && q.size() > 0;
         if (rd_ok) exp_word = q.pop_front();
         if (wr_ok) begin
            q.push_back(data_in);
            written++;
         end
         tick();
         if (rd_ok) check("stream data", int'(data_out), int'(exp_word));
         check("stream counter", int'(counter), q.size());
         cyc++;
      end
      check("stream done", int'(written == 40 && q.size() == 0), 1);
      write_n = 1'b1;
      read_n  = 1'b1;

      // Build up 5 words, then 3 cycles of read+write.
      for (int i = 0; i < 5; i++) begin
         data_in = 8'h50 + 8'(i);
         write_n = 1'b0;
         tick();
      end
      check("five counter", int'(counter), 5);
      read_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data_in = 8'h55 + 8'(i);
         tick();
         check($sformatf("rw5_%0d data", i), int'(data_out), 8'h50 + i);
         check($sformatf("rw5_%0d counter", i), int'(counter), 5);
      end

      // Reset wins over concurrent read and write.
      reset = 1'b1;
      tick();
      check_status("midreset", 0, 1, 0, 0);
      check("midreset data_out", int'(data_out), 0);
      reset   = 1'b0;
      read_n  = 1'b1;
      write_n = 1'b1;
      tick();
      check("post_reset counter", int'(counter), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
